// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the reset active level.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hazard controller.
// perf_cnt exists only when STALL_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5
`ifdef STALL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
);
  logic [NUM_STAGES-1:0] stall_req;
  logic [NUM_STAGES-1:0] flush_req;
  logic [NUM_STAGES-1:0] stall_out;
  logic [NUM_STAGES-1:0] bubble_out;
  logic [NUM_STAGES-1:0] flush_out;
  logic                  busy;
  logic                  wdt_trip;
`ifdef STALL_PERF_EN
  logic [NUM_STAGES*CNT_W-1:0] perf_cnt;
`endif

  modport master (
    output stall_req, flush_req,
    input  stall_out, bubble_out, flush_out, busy, wdt_trip
`ifdef STALL_PERF_EN
    ,
    input  perf_cnt
`endif
  );

  modport slave (
    input  stall_req, flush_req,
    output stall_out, bubble_out, flush_out, busy, wdt_trip
`ifdef STALL_PERF_EN
    ,
    output perf_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// Stall timeout counter: counts consecutive stalled cycles, raises a sticky
// trip flag when the count reaches LIMIT (LIMIT==0 never trips).
module stall_watchdog #(
  parameter int LIMIT = 1024,
  parameter int W     = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any,
  output logic trip
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         trip_q;

  // Saturate at LIMIT so a very long stall cannot wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_any) begin
      cnt_d = '0;
    end else if (cnt_q != W'(LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      trip_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if ((LIMIT != 0) && stall_any && (cnt_d == W'(LIMIT))) begin
        trip_q <= 1'b1;
      end
    end
  end

  assign trip = trip_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: freeze/bubble/flush masks, deferred flush FSM,
// stall watchdog. Optional per-stage stall counters under `STALL_PERF_EN`.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDT_LIMIT    = 1024
`ifdef STALL_PERF_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int SW        = $clog2(NUM_STAGES);
  localparam int FCW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WDT_W     = (WDT_LIMIT > 0) ? $clog2(WDT_LIMIT + 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  logic [NUM_STAGES-1:0] stall_req, flush_req;
  logic [NUM_STAGES-1:0] raw_stall, bubble_raw, fmask, stall_fin;
  logic [SW-1:0]         f_idx, f_eff;
  logic                  flush_valid, rst_ok;

  state_e                state_q;
  logic [NUM_STAGES-1:0] mask_q, flush_q;
  logic [SW-1:0]         f_q;
  logic [FCW-1:0]        cnt_q;
  logic                  busy_q;

  assign stall_req = bus.stall_req;
  assign flush_req = bus.flush_req;
  assign rst_ok    = (rst != RST_ACTIVE);

  // raw_stall[k]: some stage at or above k stalls, so k is frozen.
  // fmask[k]: some stage above k (never stage 0) redirects, so k is killed.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
    assign raw_stall[gi] = |(stall_req >> gi);
    assign fmask[gi]     = |(flush_req >> (gi + 1));
    if (gi == 0) begin : g_b0
      assign bubble_raw[gi] = 1'b0;
    end else begin : g_bn
      assign bubble_raw[gi] = stall_req[gi-1] & ~(|(stall_req >> gi));
    end
  end

  always_comb begin
    f_idx = '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (flush_req[k]) f_idx = SW'(k);
    end
  end

  assign flush_valid = fmask[0];
  assign f_eff       = (flush_valid && (f_idx > f_q)) ? f_idx : f_q;
  assign stall_fin   = raw_stall & ~flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      mask_q  <= '0;
      flush_q <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush_valid) begin
            mask_q <= fmask;
            busy_q <= 1'b1;
            if (!raw_stall[f_idx]) begin
              state_q <= ST_FLUSH;
              cnt_q   <= FLUSH_LOAD;
              flush_q <= fmask;
            end else begin
              state_q <= ST_PEND;
              f_q     <= f_idx;
            end
          end
        end
        ST_PEND: begin
          // Later redirects merge in; the oldest redirect decides when we may go.
          mask_q <= mask_q | fmask;
          f_q    <= f_eff;
          if (!raw_stall[f_eff]) begin
            state_q <= ST_FLUSH;
            cnt_q   <= FLUSH_LOAD;
            flush_q <= mask_q | fmask;
          end
        end
        ST_FLUSH: begin
          // A flush blocked by a freeze while already flushing is not retained.
          if (flush_valid && !raw_stall[f_idx]) begin
            mask_q  <= mask_q | fmask;
            flush_q <= mask_q | fmask;
            cnt_q   <= FLUSH_LOAD;
          end else if (cnt_q == '0) begin
            state_q <= ST_RUN;
            mask_q  <= '0;
            flush_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          mask_q  <= '0;
          flush_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_out  = rst_ok ? stall_fin  : '0;
  assign bus.bubble_out = rst_ok ? bubble_raw : '0;
  assign bus.flush_out  = flush_q;
  assign bus.busy       = busy_q;

  stall_watchdog #(
    .LIMIT (WDT_LIMIT),
    .W     (WDT_W)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .stall_any (|stall_req),
    .trip      (bus.wdt_trip)
  );

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0]            perf_q [NUM_STAGES];
  logic [NUM_STAGES*CNT_W-1:0] perf_flat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_STAGES; k++) perf_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (stall_fin[k] && (perf_q[k] != '1)) perf_q[k] <= perf_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    perf_flat = '0;
    for (int k = 0; k < NUM_STAGES; k++) perf_flat[k*CNT_W +: CNT_W] = perf_q[k];
  end

  assign bus.perf_cnt = perf_flat;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int FC = 3;
  localparam int WL = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(
    .NUM_STAGES(NS)
`ifdef STALL_PERF_EN
    , .CNT_W(CW)
`endif
  ) bus ();

  pipe_hazard_ctrl #(
    .NUM_STAGES   (NS),
    .FLUSH_CYCLES (FC),
    .WDT_LIMIT    (WL)
`ifdef STALL_PERF_EN
    , .CNT_W      (CW)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: pending redirect, remaining flush cycles, kill mask.
  bit            m_pend;
  int            m_fp;
  int            m_hold;
  logic [NS-1:0] m_mask;
  int            m_run;
  bit            m_trip;
  int            m_perf [NS];

  logic [NS-1:0] e_stall, e_bubble, e_flush;
  logic          e_busy, e_trip;

  function automatic logic [NS-1:0] low_bits(int n);
    logic [NS-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int top_bit(logic [NS-1:0] v, int lo);
    int t;
    t = -1;
    for (int i = lo; i < NS; i++) if (v[i]) t = i;
    return t;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_fp = 0; m_hold = 0; m_mask = '0; m_run = 0; m_trip = 0;
    for (int k = 0; k < NS; k++) m_perf[k] = 0;
  endtask

  task automatic calc_exp();
    int h;
    h = top_bit(bus.stall_req, 0);
    e_flush  = (m_hold > 0) ? m_mask : '0;
    e_stall  = low_bits(h + 1) & ~e_flush;
    e_bubble = '0;
    if (h >= 0 && h + 1 < NS) e_bubble[h+1] = 1'b1;
    e_busy = m_pend || (m_hold > 0);
    e_trip = m_trip;
  endtask

  task automatic model_step();
    int h, f;
    calc_exp();
    h = top_bit(bus.stall_req, 0);
    f = top_bit(bus.flush_req, 1);
    for (int k = 0; k < NS; k++)
      if (e_stall[k] && m_perf[k] < (1 << CW) - 1) m_perf[k]++;
    if (bus.stall_req != '0) begin
      m_run++;
      if (WL > 0 && m_run >= WL) m_trip = 1;
    end else begin
      m_run = 0;
    end
    if (m_hold > 0) begin
      if (f > 0 && h < f) begin
        m_mask |= low_bits(f);
        m_hold = FC;
      end else begin
        m_hold--;
        if (m_hold == 0) m_mask = '0;
      end
    end else if (m_pend) begin
      if (f > 0) begin
        m_mask |= low_bits(f);
        if (f > m_fp) m_fp = f;
      end
      if (h < m_fp) begin
        m_pend = 0;
        m_hold = FC;
      end
    end else if (f > 0) begin
      m_mask = low_bits(f);
      if (h < f) m_hold = FC;
      else begin
        m_pend = 1;
        m_fp   = f;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic drive(logic [NS-1:0] s, logic [NS-1:0] f);
    @(negedge clk);
    bus.stall_req = s;
    bus.flush_req = f;
    #1;
    calc_exp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.stall_req = '0;
    bus.flush_req = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.stall_req = 5'b00100;
    bus.flush_req = 5'b01000;
    #1;
    n_chk += 5;
    if (bus.stall_out !== 5'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=00000", bus.stall_out); end
    if (bus.bubble_out !== 5'b0) begin n_fail++; $display("FAIL reset_bubble got=%b exp=00000", bus.bubble_out); end
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=00000", bus.flush_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.wdt_trip !== 1'b0) begin n_fail++; $display("FAIL reset_wdt got=%b exp=0", bus.wdt_trip); end
    $display("test_reset: outputs held low during reset");
    do_reset();
  endtask

  task automatic test_masks();
    drive(5'b00100, 5'b0);
    n_chk += 4;
    if (bus.stall_out !== 5'b00111) begin n_fail++; $display("FAIL mask1_stall got=%b exp=00111", bus.stall_out); end
    if (bus.bubble_out !== 5'b01000) begin n_fail++; $display("FAIL mask1_bubble got=%b exp=01000", bus.bubble_out); end
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL mask1_flush got=%b exp=00000", bus.flush_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mask1_busy got=%b exp=0", bus.busy); end
    $display("test_masks: stall_req=00100 stall_out=%b bubble_out=%b", bus.stall_out, bus.bubble_out);
    tick();
    drive(5'b10010, 5'b0);
    n_chk += 2;
    if (bus.stall_out !== 5'b11111) begin n_fail++; $display("FAIL mask2_stall got=%b exp=11111", bus.stall_out); end
    if (bus.bubble_out !== 5'b00000) begin n_fail++; $display("FAIL mask2_bubble got=%b exp=00000", bus.bubble_out); end
    $display("test_masks: stall_req=10010 stall_out=%b bubble_out=%b", bus.stall_out, bus.bubble_out);
    tick();
    drive(5'b0, 5'b0);
    n_chk++;
    if (bus.stall_out !== 5'b0) begin n_fail++; $display("FAIL mask3_stall got=%b exp=00000", bus.stall_out); end
    tick();
  endtask

  task automatic test_flush();
    drive(5'b0, 5'b01000);
    n_chk++;
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL flush_lat got=%b exp=00000", bus.flush_out); end
    tick();
    for (int i = 0; i < FC; i++) begin
      drive(5'b0, 5'b0);
      n_chk += 2;
      if (bus.flush_out !== 5'b00111) begin n_fail++; $display("FAIL flush_hold%0d got=%b exp=00111", i, bus.flush_out); end
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy%0d got=%b exp=1", i, bus.busy); end
      $display("test_flush: cycle %0d flush_out=%b busy=%b", i, bus.flush_out, bus.busy);
      tick();
    end
    drive(5'b0, 5'b0);
    n_chk += 2;
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL flush_end got=%b exp=00000", bus.flush_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b exp=0", bus.busy); end
    tick();
  endtask

  task automatic test_pend();
    for (int i = 0; i < 3; i++) begin
      drive(5'b10000, (i == 0) ? 5'b00100 : 5'b0);
      if (i > 0) begin
        n_chk += 3;
        if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL pend_flush%0d got=%b exp=00000", i, bus.flush_out); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy%0d got=%b exp=1", i, bus.busy); end
        if (bus.stall_out !== 5'b11111) begin n_fail++; $display("FAIL pend_stall%0d got=%b exp=11111", i, bus.stall_out); end
      end
      $display("test_pend: cycle %0d flush_out=%b busy=%b", i, bus.flush_out, bus.busy);
      tick();
    end
    drive(5'b0, 5'b0);
    n_chk++;
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL pend_release got=%b exp=00000", bus.flush_out); end
    tick();
    drive(5'b0, 5'b0);
    n_chk++;
    if (bus.flush_out !== 5'b00011) begin n_fail++; $display("FAIL pend_fire got=%b exp=00011", bus.flush_out); end
    $display("test_pend: released flush_out=%b", bus.flush_out);
    tick();
    for (int i = 0; i < FC + 1; i++) begin drive(5'b0, 5'b0); tick(); end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    drive(5'b0, 5'b01000);
    tick();
    drive(5'b0, 5'b00100);
    if (bus.flush_out != 5'b0) seen++;
    tick();
    for (int i = 0; i < FC + 2; i++) begin
      drive(5'b0, 5'b0);
      n_chk++;
      if (bus.flush_out !== e_flush) begin n_fail++; $display("FAIL b2b_flush%0d got=%b exp=%b", i, bus.flush_out, e_flush); end
      if (bus.flush_out != 5'b0) seen++;
      tick();
    end
    n_chk++;
    if (seen !== FC + 1) begin n_fail++; $display("FAIL b2b_len got=%0d exp=%0d", seen, FC + 1); end
    $display("test_back_to_back: flush asserted %0d cycles", seen);
  endtask

  task automatic test_wdt();
    drive(5'b0, 5'b0);
    tick();
    for (int i = 0; i < WL; i++) begin
      drive(5'b00001, 5'b0);
      if (i == WL - 1) begin
        n_chk++;
        if (bus.wdt_trip !== 1'b0) begin n_fail++; $display("FAIL wdt_early got=%b exp=0", bus.wdt_trip); end
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(5'b0, 5'b0);
      n_chk++;
      if (bus.wdt_trip !== 1'b1) begin n_fail++; $display("FAIL wdt_sticky%0d got=%b exp=1", i, bus.wdt_trip); end
      $display("test_wdt: after stall wdt_trip=%b", bus.wdt_trip);
      tick();
    end
    do_reset();
    drive(5'b0, 5'b0);
    n_chk++;
    if (bus.wdt_trip !== 1'b0) begin n_fail++; $display("FAIL wdt_clear got=%b exp=0", bus.wdt_trip); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    drive(5'b0, 5'b10000);
    tick();
    drive(5'b00100, 5'b0);
    n_chk++;
    if (bus.flush_out !== 5'b01111) begin n_fail++; $display("FAIL mid_flush got=%b exp=01111", bus.flush_out); end
    #2;
    rst = 1'b0;
    #1;
    n_chk += 4;
    if (bus.stall_out !== 5'b0) begin n_fail++; $display("FAIL mid_rst_stall got=%b exp=00000", bus.stall_out); end
    if (bus.bubble_out !== 5'b0) begin n_fail++; $display("FAIL mid_rst_bubble got=%b exp=00000", bus.bubble_out); end
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL mid_rst_flush got=%b exp=00000", bus.flush_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stall_req = '0;
    tick();
    drive(5'b0, 5'b0);
    n_chk += 2;
    if (bus.flush_out !== 5'b0) begin n_fail++; $display("FAIL post_rst_flush got=%b exp=00000", bus.flush_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got=%b exp=0", bus.busy); end
    $display("test_reset_mid_flush: flush_out=%b busy=%b", bus.flush_out, bus.busy);
    tick();
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 20; i++) begin drive(5'b00001, 5'b0); tick(); end
    drive(5'b0, 5'b0);
    n_chk += 2;
    if (bus.perf_cnt[CW-1:0] !== 4'd15) begin n_fail++; $display("FAIL perf_sat got=%0d exp=15", bus.perf_cnt[CW-1:0]); end
    if (bus.perf_cnt[2*CW-1:CW] !== 4'd0) begin n_fail++; $display("FAIL perf_s1 got=%0d exp=0", bus.perf_cnt[2*CW-1:CW]); end
    $display("test_perf: stage0 count=%0d", bus.perf_cnt[CW-1:0]);
    tick();
  endtask
`endif

  task automatic test_random();
    logic [NS-1:0] s, f;
    for (int c = 0; c < 300; c++) begin
      s = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      f = ($urandom_range(0, 4) == 0) ? NS'($urandom) : '0;
      drive(s, f);
      n_chk += 5;
      if (bus.stall_out !== e_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.stall_out, e_stall); end
      if (bus.bubble_out !== e_bubble) begin n_fail++; $display("FAIL rnd_bubble c=%0d got=%b exp=%b", c, bus.bubble_out, e_bubble); end
      if (bus.flush_out !== e_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, bus.flush_out, e_flush); end
      if (bus.busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy, e_busy); end
      if (bus.wdt_trip !== e_trip) begin n_fail++; $display("FAIL rnd_wdt c=%0d got=%b exp=%b", c, bus.wdt_trip, e_trip); end
`ifdef STALL_PERF_EN
      for (int k = 0; k < NS; k++) begin
        n_chk++;
        if (bus.perf_cnt[k*CW +: CW] !== CW'(m_perf[k])) begin
          n_fail++;
          $display("FAIL rnd_perf c=%0d k=%0d got=%0d exp=%0d", c, k, bus.perf_cnt[k*CW +: CW], m_perf[k]);
        end
      end
`endif
      $display("rnd %0d stall_req=%b flush_req=%b stall_out=%b bubble_out=%b flush_out=%b busy=%b",
               c, s, f, bus.stall_out, bus.bubble_out, bus.flush_out, bus.busy);
      tick();
    end
  endtask

  initial begin
    bus.stall_req = '0;
    bus.flush_req = '0;
    model_reset();
    test_reset();
    test_masks();
    test_flush();
    test_pend();
    test_back_to_back();
    test_wdt();
    test_reset_mid_flush();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
